// File: rtl/vga_timing_pkg.sv
// Shared constants and helpers for the VGA raster timing generator.
// Defaults describe 640x480@60 from a 100 MHz system clock.
package vga_timing_pkg;

    localparam int DEF_CLK_DIV  = 4;
    localparam int DEF_CNT_W    = 10;
    localparam int DEF_H_VIS    = 640;
    localparam int DEF_H_FP     = 16;
    localparam int DEF_H_SYNC   = 96;
    localparam int DEF_H_BP     = 48;
    localparam int DEF_V_VIS    = 480;
    localparam int DEF_V_FP     = 10;
    localparam int DEF_V_SYNC   = 2;
    localparam int DEF_V_BP     = 33;
    localparam int DEF_SYNC_POL = 0;

    // Full period of one axis (visible + porches + sync)
    function automatic int total_len(input int vis, input int fp, input int sync, input int bp);
        return vis + fp + sync + bp;
    endfunction

    // First count at which the sync pulse is asserted
    function automatic int sync_start(input int vis, input int fp);
        return vis + fp;
    endfunction

    // First count after the sync pulse (exclusive end)
    function automatic int sync_end(input int vis, input int fp, input int sync);
        return vis + fp + sync;
    endfunction

endpackage

// File: rtl/vga_timing_gen_if.sv
// Raster timing bundle from the timing generator to its consumers.
// frame_cnt exists only when VGA_FRAME_CNT_EN is defined.
interface vga_timing_gen_if #(
    parameter int CNT_W = 10
);
    logic             pix_en;
    logic [CNT_W-1:0] h_count;
    logic [CNT_W-1:0] v_count;
    logic             h_sync;
    logic             v_sync;
    logic             video_on;
    logic             line_start;
    logic             frame_start;
`ifdef VGA_FRAME_CNT_EN
    logic [15:0]      frame_cnt;
`endif

    modport master (
        output pix_en, h_count, v_count, h_sync, v_sync,
        output video_on, line_start, frame_start
`ifdef VGA_FRAME_CNT_EN
        , output frame_cnt
`endif
    );

    modport slave (
        input pix_en, h_count, v_count, h_sync, v_sync,
        input video_on, line_start, frame_start
`ifdef VGA_FRAME_CNT_EN
        , input frame_cnt
`endif
    );
endinterface

// File: rtl/vga_pix_en_div.sv
// Pixel-enable divider: one-clk pix_en every CLK_DIV system clocks.
// pix_en is registered so it stays low in reset even when CLK_DIV==1.
module vga_pix_en_div import vga_timing_pkg::*; #(
    parameter int CLK_DIV = DEF_CLK_DIV
) (
    input  logic clk,
    input  logic reset,
    output logic pix_en
);
    localparam int DIV_W = (CLK_DIV > 1) ? $clog2(CLK_DIV) : 1;
    localparam logic [DIV_W-1:0] DIV_LAST = DIV_W'(CLK_DIV - 1);

    logic [DIV_W-1:0] div_reg;
    logic [DIV_W-1:0] div_next;
    logic             pix_en_reg;

    // Next divider value, wrapping after CLK_DIV-1
    always_comb begin
        div_next = (div_reg == DIV_LAST) ? '0 : div_reg + DIV_W'(1);
    end

    // pix_en coincides with the cycle in which the divider sits at its last value
    always_ff @(posedge clk) begin
        if (!reset) begin
            div_reg    <= '0;
            pix_en_reg <= 1'b0;
        end else begin
            div_reg    <= div_next;
            pix_en_reg <= (div_next == DIV_LAST);
        end
    end

    assign pix_en = pix_en_reg;
endmodule

// File: rtl/vga_timing_gen.sv
// Parametrised VGA raster timing generator.
// Optional feature: define VGA_FRAME_CNT_EN to add a 16-bit completed-frame counter.
// All outputs are registered from the next counter values so they line up with the counts.
module vga_timing_gen import vga_timing_pkg::*; #(
    parameter int CLK_DIV  = DEF_CLK_DIV,
    parameter int CNT_W    = DEF_CNT_W,
    parameter int H_VIS    = DEF_H_VIS,
    parameter int H_FP     = DEF_H_FP,
    parameter int H_SYNC   = DEF_H_SYNC,
    parameter int H_BP     = DEF_H_BP,
    parameter int V_VIS    = DEF_V_VIS,
    parameter int V_FP     = DEF_V_FP,
    parameter int V_SYNC   = DEF_V_SYNC,
    parameter int V_BP     = DEF_V_BP,
    parameter int SYNC_POL = DEF_SYNC_POL
) (
    input  logic              clk,
    input  logic              reset,
    vga_timing_gen_if.master  vga
);
    localparam logic [CNT_W-1:0] H_LAST   = CNT_W'(total_len(H_VIS, H_FP, H_SYNC, H_BP) - 1);
    localparam logic [CNT_W-1:0] V_LAST   = CNT_W'(total_len(V_VIS, V_FP, V_SYNC, V_BP) - 1);
    localparam logic [CNT_W-1:0] H_VIS_C  = CNT_W'(H_VIS);
    localparam logic [CNT_W-1:0] V_VIS_C  = CNT_W'(V_VIS);
    localparam logic [CNT_W-1:0] HS_START = CNT_W'(sync_start(H_VIS, H_FP));
    localparam logic [CNT_W-1:0] HS_END   = CNT_W'(sync_end(H_VIS, H_FP, H_SYNC));
    localparam logic [CNT_W-1:0] VS_START = CNT_W'(sync_start(V_VIS, V_FP));
    localparam logic [CNT_W-1:0] VS_END   = CNT_W'(sync_end(V_VIS, V_FP, V_SYNC));
    localparam logic             SYNC_ACT = (SYNC_POL != 0);

    logic             pix_en;
    logic [CNT_W-1:0] h_count_reg, h_next;
    logic [CNT_W-1:0] v_count_reg, v_next;
    logic             h_sync_reg;
    logic             v_sync_reg;
    logic             video_on_reg;
    logic             line_start_reg;
    logic             frame_start_reg;

    vga_pix_en_div #(
        .CLK_DIV (CLK_DIV)
    ) u_div (
        .clk    (clk),
        .reset  (reset),
        .pix_en (pix_en)
    );

    // Counter values after the next pixel tick
    always_comb begin
        h_next = h_count_reg + CNT_W'(1);
        v_next = v_count_reg;
        if (h_count_reg == H_LAST) begin
            h_next = '0;
            v_next = (v_count_reg == V_LAST) ? '0 : v_count_reg + CNT_W'(1);
        end
    end

    // Raster counters and the outputs decoded from the values they are about to take
    always_ff @(posedge clk) begin
        if (!reset) begin
            h_count_reg     <= '0;
            v_count_reg     <= '0;
            h_sync_reg      <= ~SYNC_ACT;
            v_sync_reg      <= ~SYNC_ACT;
            video_on_reg    <= 1'b0;
            line_start_reg  <= 1'b0;
            frame_start_reg <= 1'b0;
        end else if (pix_en) begin
            h_count_reg     <= h_next;
            v_count_reg     <= v_next;
            h_sync_reg      <= (h_next >= HS_START && h_next < HS_END) ? SYNC_ACT : ~SYNC_ACT;
            v_sync_reg      <= (v_next >= VS_START && v_next < VS_END) ? SYNC_ACT : ~SYNC_ACT;
            video_on_reg    <= (h_next < H_VIS_C) && (v_next < V_VIS_C);
            line_start_reg  <= (h_next == '0);
            frame_start_reg <= (h_next == '0) && (v_next == '0);
        end else begin
            line_start_reg  <= 1'b0;
            frame_start_reg <= 1'b0;
        end
    end

`ifdef VGA_FRAME_CNT_EN
    logic [15:0] frame_cnt_reg;

    // Completed frames, bumped together with frame_start and wrapping at 16 bits
    always_ff @(posedge clk) begin
        if (!reset) begin
            frame_cnt_reg <= '0;
        end else if (pix_en && h_next == '0 && v_next == '0) begin
            frame_cnt_reg <= frame_cnt_reg + 16'd1;
        end
    end

    assign vga.frame_cnt = frame_cnt_reg;
`else
    // No frame counter in this build
`endif

    assign vga.pix_en      = pix_en;
    assign vga.h_count     = h_count_reg;
    assign vga.v_count     = v_count_reg;
    assign vga.h_sync      = h_sync_reg;
    assign vga.v_sync      = v_sync_reg;
    assign vga.video_on    = video_on_reg;
    assign vga.line_start  = line_start_reg;
    assign vga.frame_start = frame_start_reg;
endmodule
